// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_pkg
// Purpose  : Shared constants and types for the intr_ctrl interrupt
//            aggregator. Holds the register word indices, the register
//            data type and the helper that derives the irq_id width.
// Revision : 1.0 - initial release
// ============================================================================
package intr_ctrl_pkg;

   // Word index of each register, taken from reg_addr[3:2]
   localparam logic [1:0] ADDR_STATUS   = 2'd0;
   localparam logic [1:0] ADDR_MASK     = 2'd1;
   localparam logic [1:0] ADDR_CLEAR    = 2'd2;
   localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

   typedef logic [31:0] reg_data_t;

   // Width needed to encode a source index. A single source still
   // needs one bit.
   function automatic int id_w(input int n_src);
      return (n_src <= 1) ? 1 : $clog2(n_src);
   endfunction

endpackage
`default_nettype wire

// File: rtl/intr_src_detect.sv
`default_nettype none
// ============================================================================
// Module   : intr_src_detect
// Purpose  : One interrupt source: optional synchroniser, delayed copy
//            (src_q) and the pending bit with level or rising-edge capture.
// Macro    : INTR_CTRL_SYNC_EN - adds a 2-flop synchroniser (reset to 0)
//            in front of the detection logic.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            src      - raw interrupt request
//            edge_sel - 1 = rising-edge sticky, 0 = level
//            clr      - write-1-to-clear strobe (edge mode only)
//            pending  - pending state of this source
// Revision : 1.0 - initial release
// ============================================================================
module intr_src_detect (
   input  logic clk,
   input  logic rst,
   input  logic src,
   input  logic edge_sel,
   input  logic clr,
   output logic pending
);

   logic src_s;        // source as seen by the detection logic
   logic src_d, src_q;
   logic pending_d, pending_q;

`ifdef INTR_CTRL_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
      end
   end

   assign src_s = sync2_q;
`else
   assign src_s = src;
`endif

   always_comb begin
      src_d = src_s;
      if (edge_sel) begin
         // A new edge beats a same-cycle clear.
         pending_d = (src_s & ~src_q) | (pending_q & ~clr);
      end else begin
         pending_d = src_s;
      end
   end

   // src_q resets high so a source already asserted when reset is
   // released is not mistaken for a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q     <= 1'b1;
         pending_q <= 1'b0;
      end else begin
         src_q     <= src_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl
// Purpose  : Interrupt aggregator. Collects N_SRC sources, applies per-source
//            level/edge detection, pending capture and masking, and drives a
//            registered IRQ plus the lowest-index active source ID.
// Macro    : INTR_CTRL_SYNC_EN - synchronise src inside each source slice.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            src                 - raw interrupt requests
//            reg_we / reg_re     - single-cycle write / read strobes
//            reg_addr            - byte address, [3:2] selects register
//            reg_wdata           - write data
//            reg_rdata/rvalid    - read response, valid for one cycle
//            irq / irq_id        - aggregated request and source ID
// Registers: 0 STATUS (RO), 1 MASK (RW), 2 CLEAR (W1C), 3 EDGE_SEL (RW)
// Revision : 1.0 - initial release
// ============================================================================
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int N_SRC = 8,
   parameter int ID_W  = id_w(N_SRC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src,
   input  logic             reg_we,
   input  logic             reg_re,
   input  logic [3:0]       reg_addr,
   input  logic [31:0]      reg_wdata,
   output logic [31:0]      reg_rdata,
   output logic             reg_rvalid,
   output logic             irq,
   output logic [ID_W-1:0]  irq_id
);

   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] clr_vec;
   logic [N_SRC-1:0] active;

   logic [N_SRC-1:0] mask_d, mask_q;
   logic [N_SRC-1:0] edge_sel_d, edge_sel_q;
   reg_data_t        rdata_d, rdata_q;
   logic             rvalid_d, rvalid_q;
   logic             irq_d, irq_q;
   logic [ID_W-1:0]  irq_id_d, irq_id_q;

   logic [1:0]       word;
   logic             unused_bits;

   assign word = reg_addr[3:2];

   // Byte-offset bits and data bits above N_SRC carry no meaning.
   assign unused_bits = ^{reg_addr[1:0], reg_wdata};

   // ---------------------------------------------------------------------
   // Per-source detection
   // ---------------------------------------------------------------------
   assign clr_vec = (reg_we && word == ADDR_CLEAR) ? reg_wdata[N_SRC-1:0]
                                                   : '0;

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      intr_src_detect u_det (
         .clk      (clk),
         .rst      (rst),
         .src      (src[gi]),
         .edge_sel (edge_sel_q[gi]),
         .clr      (clr_vec[gi]),
         .pending  (pending[gi])
      );
   end

   // ---------------------------------------------------------------------
   // Register file; reads see the values from before a same-cycle write
   // ---------------------------------------------------------------------
   always_comb begin
      mask_d     = mask_q;
      edge_sel_d = edge_sel_q;
      rdata_d    = rdata_q;
      rvalid_d   = reg_re;

      if (reg_we) begin
         if (word == ADDR_MASK)     mask_d     = reg_wdata[N_SRC-1:0];
         if (word == ADDR_EDGE_SEL) edge_sel_d = reg_wdata[N_SRC-1:0];
      end

      if (reg_re) begin
         case (word)
            ADDR_STATUS:   rdata_d = reg_data_t'(pending);
            ADDR_MASK:     rdata_d = reg_data_t'(mask_q);
            ADDR_EDGE_SEL: rdata_d = reg_data_t'(edge_sel_q);
            default:       rdata_d = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Priority encoder: lowest index wins, so scan downwards and let the
   // last hit overwrite.
   // ---------------------------------------------------------------------
   assign active = pending & mask_q;

   always_comb begin
      irq_d    = |active;
      irq_id_d = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) irq_id_d = ID_W'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q     <= '0;
         edge_sel_q <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         irq_q      <= 1'b0;
         irq_id_q   <= '0;
      end else begin
         mask_q     <= mask_d;
         edge_sel_q <= edge_sel_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         irq_q      <= irq_d;
         irq_id_q   <= irq_id_d;
      end
   end

   assign reg_rdata  = rdata_q;
   assign reg_rvalid = rvalid_q;
   assign irq        = irq_q;
   assign irq_id     = irq_id_q;

endmodule
`default_nettype wire
